switch_bin_reader: RTL and testbench
====================================

SWITCH_BIN_READER -- requirements
Module: switch_bin_reader

Interface
REQ-001 SHALL have parameter: DEBOUNCE_CYCLES, default 100000, consecutive stable clock cycles required to accept a new switch level (legal range >= 1).
REQ-002 SHALL have port: clk  input  1  single system clock; all logic on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port: sw  input  4  raw, asynchronous, bouncing switch levels; sw[0] weight 1, sw[3] weight 8.
REQ-005 SHALL have port: binNum  output  4  debounced binary number; feeds the existing LED binary display and Gray decoder.
REQ-006 SHALL have port: newValue  output  1  one-cycle pulse marking an edge on which binNum changed.

Function
REQ-007 SHALL pass each sw bit through a two-flop synchronizer (sync1, sync2) before any other use.
REQ-008 SHALL keep one debounce counter per bit, $clog2(DEBOUNCE_CYCLES+1) bits wide, saturating never (cleared before overflow).
REQ-009 SHALL, per bit per edge: if sync2 equals the current binNum bit, clear the counter; otherwise increment it.
REQ-010 SHALL, when a bit's counter equals DEBOUNCE_CYCLES-1 and sync2 still differs, load sync2 into that binNum bit and clear the counter on the same edge.
REQ-011 SHALL give latency: counting the first rising edge that samples a new, steady sw level as edge 1, binNum updates on edge DEBOUNCE_CYCLES+2.
REQ-012 SHALL discard a partial count whenever sync2 returns to the binNum level (glitch shorter than DEBOUNCE_CYCLES after sync leaves binNum unchanged).
REQ-013 SHALL debounce the four bits independently; bits settling on different edges update binNum on different edges.
REQ-014 SHALL register newValue high for exactly the cycle following any edge on which at least one binNum bit changed; simultaneous bit updates produce one pulse.
REQ-015 SHALL, with DEBOUNCE_CYCLES=1, update a bit on the first comparison edge where sync2 differs (edge 3).
REQ-016 SHALL never change binNum or pulse newValue while sw is constant at the binNum value.

Reset
REQ-017 SHALL, on any edge with rst=1, set sync1, sync2, all counters, binNum and newValue to 0.
REQ-018 SHALL, on reset asserted mid-debounce, abandon the count; after release a steady nonzero sw yields its value on edge DEBOUNCE_CYCLES+2 after release, with one newValue pulse.
REQ-019 SHALL hold all outputs at 0 for every cycle rst is high, regardless of sw.

Structure
REQ-020 SHALL place in shared package bin_io_pkg: NIBBLE_W=4, typedef nibble_t (logic [3:0]), DEBOUNCE_DEFAULT=100000.
REQ-021 SHALL implement one sub-module switch_debouncer (one bit: synchronizer, counter, stable flop, change strobe), instantiated four times; top ORs the strobes and registers newValue.
REQ-022 SHALL contain no latches, no gated clocks, no asynchronous reset.

Verification (DEBOUNCE_CYCLES=4 unless stated)
REQ-023 SHALL cover reset: rst high 3 cycles with sw=1010 -> binNum=0000, newValue=0 throughout; after release binNum=1010 on edge 6, newValue high exactly one cycle.
REQ-024 SHALL cover clean step: sw 0000->0101 held -> binNum=0101 on edge 6, single newValue pulse, no further pulses over 20 cycles.
REQ-025 SHALL cover glitch: sw[0] high for 3 cycles then low -> binNum stays 0000, newValue never asserted.
REQ-026 SHALL cover staggered bits: sw[3] rises, sw[1] rises 2 cycles later -> binNum 1000 on edge 6, 1010 on edge 8, two separate newValue pulses.
REQ-027 SHALL cover bounce: sw[2] toggles every cycle for 10 cycles then holds 1 -> binNum=0100 on edge 6 after final toggle, exactly one pulse.
REQ-028 SHALL cover reset mid-debounce: sw=1111 applied, rst pulsed on edge 4 -> binNum=0000 after reset, binNum=1111 on edge 6 after release.

Source files
------------

// File: rtl/bin_io_pkg.sv
// Shared types and constants for the switch binary input path.
// Provides the nibble width/type and the default debounce length.
package bin_io_pkg;

   localparam int NIBBLE_W = 4;

   typedef logic [NIBBLE_W-1:0] nibble_t;

   localparam int DEBOUNCE_DEFAULT = 100000;

endpackage

// File: rtl/switch_debouncer.sv
// One-bit switch debouncer: two-flop synchronizer, stability counter,
// debounced level flop and a combinational change strobe.
// Ports: clk, rst (sync, active-high), sw_i (raw async level),
//        stable_o (debounced level), change_o (high on the edge stable_o flips).
module switch_debouncer
   import bin_io_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
   input  logic clk,
   input  logic rst,
   input  logic sw_i,
   output logic stable_o,
   output logic change_o
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync1_q, sync1_d;
   logic             sync2_q, sync2_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             stable_q, stable_d;

   always_comb begin
      sync1_d  = sw_i;
      sync2_d  = sync1_q;
      cnt_d    = cnt_q;
      stable_d = stable_q;
      change_o = 1'b0;
      if (sync2_q == stable_q) begin
         // level back at the accepted value: drop any partial count
         cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
         stable_d = sync2_q;
         cnt_d    = '0;
         change_o = 1'b1;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q  <= 1'b0;
         sync2_q  <= 1'b0;
         cnt_q    <= '0;
         stable_q <= 1'b0;
      end else begin
         sync1_q  <= sync1_d;
         sync2_q  <= sync2_d;
         cnt_q    <= cnt_d;
         stable_q <= stable_d;
      end
   end

   assign stable_o = stable_q;

endmodule

// File: rtl/switch_bin_reader.sv
// Reads four bouncing switches as a debounced 4-bit binary number.
// Ports: clk, rst (sync, active-high), sw[3:0] (raw switches),
//        binNum[3:0] (debounced value), newValue (1-cycle change pulse).
module switch_bin_reader
   import bin_io_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NIBBLE_W-1:0] sw,
   output nibble_t             binNum,
   output logic                newValue
);

   nibble_t stable_w;
   nibble_t change_w;
   logic    newValue_q, newValue_d;

   for (genvar i = 0; i < NIBBLE_W; i++) begin : g_bit
      switch_debouncer #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_deb (
         .clk      (clk),
         .rst      (rst),
         .sw_i     (sw[i]),
         .stable_o (stable_w[i]),
         .change_o (change_w[i])
      );
   end

   // bits flipping on the same edge merge into a single pulse
   always_comb begin
      newValue_d = |change_w;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         newValue_q <= 1'b0;
      end else begin
         newValue_q <= newValue_d;
      end
   end

   assign binNum   = stable_w;
   assign newValue = newValue_q;

endmodule

// File: tb/tb_switch_bin_reader.sv
// Directed table-driven bench for switch_bin_reader (D=4 and D=1).
// Each step drives inputs, clocks one edge and checks outputs 1ns later.
module tb_switch_bin_reader;

   logic       clk;
   logic       rst;
   logic [3:0] sw;
   logic [3:0] bin_a;
   logic       nv_a;
   logic [3:0] bin_b;
   logic       nv_b;

   int n_checks;
   int n_fail;
   int cyc;

   typedef struct {
      logic       rst;
      logic [3:0] sw;
      logic [3:0] bin;
      logic       nv;
      int         n;
   } vec_t;

   vec_t vec[$];

   switch_bin_reader #(.DEBOUNCE_CYCLES(4)) dut_a (
      .clk      (clk),
      .rst      (rst),
      .sw       (sw),
      .binNum   (bin_a),
      .newValue (nv_a)
   );

   switch_bin_reader #(.DEBOUNCE_CYCLES(1)) dut_b (
      .clk      (clk),
      .rst      (rst),
      .sw       (sw),
      .binNum   (bin_b),
      .newValue (nv_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [3:0] act,
                        input logic [3:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s cyc=%0d: got %b expected %b", nm, cyc, act, exp);
      end
   endtask

   task automatic step(input logic r, input logic [3:0] s,
                       input logic [3:0] eb, input logic en,
                       input bit chk_b, input logic [3:0] eb_b,
                       input logic en_b);
      rst = r;
      sw  = s;
      @(posedge clk);
      #1;
      cyc++;
      check("binNum", bin_a, eb);
      check("newValue", {3'b0, nv_a}, {3'b0, en});
      if (chk_b) begin
         check("binNum_d1", bin_b, eb_b);
         check("newValue_d1", {3'b0, nv_b}, {3'b0, en_b});
      end
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      cyc      = 0;
      rst      = 1'b1;
      sw       = 4'b0000;

      // reset with sw=1010, release, value on edge 6
      vec.push_back('{1'b1, 4'b1010, 4'b0000, 1'b0, 3});
      vec.push_back('{1'b0, 4'b1010, 4'b0000, 1'b0, 5});
      vec.push_back('{1'b0, 4'b1010, 4'b1010, 1'b1, 1});
      vec.push_back('{1'b0, 4'b1010, 4'b1010, 1'b0, 3});
      vec.push_back('{1'b1, 4'b0000, 4'b0000, 1'b0, 2});
      // clean step 0000 -> 0101, then 20 quiet cycles
      vec.push_back('{1'b0, 4'b0101, 4'b0000, 1'b0, 5});
      vec.push_back('{1'b0, 4'b0101, 4'b0101, 1'b1, 1});
      vec.push_back('{1'b0, 4'b0101, 4'b0101, 1'b0, 20});
      vec.push_back('{1'b1, 4'b0000, 4'b0000, 1'b0, 2});
      // glitch on sw[0] for 3 cycles
      vec.push_back('{1'b0, 4'b0001, 4'b0000, 1'b0, 3});
      vec.push_back('{1'b0, 4'b0000, 4'b0000, 1'b0, 10});
      // staggered bits: sw[3], then sw[1] two cycles later
      vec.push_back('{1'b0, 4'b1000, 4'b0000, 1'b0, 2});
      vec.push_back('{1'b0, 4'b1010, 4'b0000, 1'b0, 3});
      vec.push_back('{1'b0, 4'b1010, 4'b1000, 1'b1, 1});
      vec.push_back('{1'b0, 4'b1010, 4'b1000, 1'b0, 1});
      vec.push_back('{1'b0, 4'b1010, 4'b1010, 1'b1, 1});
      vec.push_back('{1'b0, 4'b1010, 4'b1010, 1'b0, 5});
      vec.push_back('{1'b1, 4'b0000, 4'b0000, 1'b0, 2});
      // reset pulsed on edge 4 of a 1111 debounce
      vec.push_back('{1'b0, 4'b1111, 4'b0000, 1'b0, 3});
      vec.push_back('{1'b1, 4'b1111, 4'b0000, 1'b0, 1});
      vec.push_back('{1'b0, 4'b1111, 4'b0000, 1'b0, 5});
      vec.push_back('{1'b0, 4'b1111, 4'b1111, 1'b1, 1});
      vec.push_back('{1'b0, 4'b1111, 4'b1111, 1'b0, 3});
      vec.push_back('{1'b1, 4'b0000, 4'b0000, 1'b0, 2});

      foreach (vec[i]) begin
         for (int k = 0; k < vec[i].n; k++) begin
            step(vec[i].rst, vec[i].sw, vec[i].bin, vec[i].nv,
                 1'b0, 4'b0000, 1'b0);
         end
      end

      // bounce: sw[2] toggles 10 cycles, then holds high
      for (int i = 0; i < 10; i++) begin
         step(1'b0, (i % 2 == 0) ? 4'b0100 : 4'b0000,
              4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0);
      end
      for (int k = 1; k <= 15; k++) begin
         step(1'b0, 4'b0100, (k >= 6) ? 4'b0100 : 4'b0000,
              (k == 6), 1'b0, 4'b0000, 1'b0);
      end

      // DEBOUNCE_CYCLES=1 updates on edge 3, D=4 on edge 6
      step(1'b1, 4'b0000, 4'b0000, 1'b0, 1'b1, 4'b0000, 1'b0);
      step(1'b1, 4'b0000, 4'b0000, 1'b0, 1'b1, 4'b0000, 1'b0);
      for (int k = 1; k <= 8; k++) begin
         step(1'b0, 4'b0110, (k >= 6) ? 4'b0110 : 4'b0000, (k == 6),
              1'b1, (k >= 3) ? 4'b0110 : 4'b0000, (k == 3));
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
